dmem_bridge: RTL

- Sits directly upstream of the byte-wide synchronous data RAM and owns that RAM's port.
- Converts AVR core data-space load/store requests (byte or 16-bit little-endian word, 16-bit data-space address) into RAM strobes.
- Range-checks each access against the SRAM window and absorbs the RAM's one-cycle registered read latency.
- Returns a single-cycle response pulse to the core.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_decode.sv | 29 ++
 rtl/dmem_bridge.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the AVR data-memory bridge.
package dmem_pkg;

   localparam int unsigned DataAddrWidth = 16;
   localparam logic [DataAddrWidth-1:0] DefaultRamBase = 16'h0100;

   typedef enum logic [2:0] {
      StIdle,
      StLo,
      StHi,
      StCap,
      StRsp
   } state_e;

endpackage

// File: rtl/dmem_decode.sv
// Window check and RAM offset for a single data-space byte address.
module dmem_decode
   import dmem_pkg::*;
#(
   parameter int unsigned ram_width = 11,
   parameter logic [DataAddrWidth-1:0] ram_base = DefaultRamBase
) (
   input  logic [DataAddrWidth-1:0] addr,
   output logic                     in_range,
   output logic [ram_width-1:0]     offset
);

   // One extra bit so a window ending at 0x10000 does not wrap.
   localparam logic [DataAddrWidth:0] WinLo = {1'b0, ram_base};
   localparam logic [DataAddrWidth:0] WinHi =
      WinLo + ({{DataAddrWidth{1'b0}}, 1'b1} << ram_width);

   logic [DataAddrWidth:0]   addr_ext;
   logic [DataAddrWidth-1:0] diff;

   always_comb begin
      addr_ext = {1'b0, addr};
      in_range = (addr_ext >= WinLo) && (addr_ext < WinHi);
      diff     = addr - ram_base;
   end

   assign offset = diff[ram_width-1:0];

endmodule

// File: rtl/dmem_bridge.sv
// AVR data-space load/store bridge onto a byte-wide RAM with one-cycle read latency.
module dmem_bridge
   import dmem_pkg::*;
#(
   parameter int unsigned ram_width = 11,
   parameter logic [DataAddrWidth-1:0] ram_base = DefaultRamBase
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req,
   input  logic                     req_we,
   input  logic                     req_word,
   input  logic [DataAddrWidth-1:0] req_addr,
   input  logic [15:0]              req_wdata,
   output logic                     req_ready,
   output logic                     rsp_valid,
   output logic                     rsp_err,
   output logic [15:0]              rsp_rdata,
   output logic                     ram_re,
   output logic                     ram_we,
   output logic [ram_width-1:0]     ram_addr,
   output logic [7:0]               ram_wdata,
   input  logic [7:0]               ram_rdata
);

   state_e                   state;
   logic                     we_q;
   logic                     word_q;
   logic [7:0]               wdata_hi_q;
   logic [7:0]               lo_byte_q;
   logic [ram_width-1:0]     hi_off_q;

   logic [DataAddrWidth-1:0] hi_addr;
   logic                     lo_ok;
   logic                     hi_ok;
   logic [ram_width-1:0]     lo_off;
   logic [ram_width-1:0]     hi_off;
   logic                     acc_ok;

   assign hi_addr = req_addr + 16'd1;

   dmem_decode #(
      .ram_width (ram_width),
      .ram_base  (ram_base)
   ) u_decode_lo (
      .addr     (req_addr),
      .in_range (lo_ok),
      .offset   (lo_off)
   );

   dmem_decode #(
      .ram_width (ram_width),
      .ram_base  (ram_base)
   ) u_decode_hi (
      .addr     (hi_addr),
      .in_range (hi_ok),
      .offset   (hi_off)
   );

   assign acc_ok    = lo_ok && (!req_word || hi_ok);
   assign req_ready = (state == StIdle);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StIdle;
         we_q       <= 1'b0;
         word_q     <= 1'b0;
         wdata_hi_q <= 8'h00;
         lo_byte_q  <= 8'h00;
         hi_off_q   <= '0;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= 16'h0000;
         ram_re     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= 8'h00;
      end else begin
         case (state)
            StIdle: begin
               if (req) begin
                  we_q       <= req_we;
                  word_q     <= req_word;
                  wdata_hi_q <= req_wdata[15:8];
                  hi_off_q   <= hi_off;
                  if (acc_ok) begin
                     state     <= StLo;
                     ram_we    <= req_we;
                     ram_re    <= !req_we;
                     ram_addr  <= lo_off;
                     ram_wdata <= req_wdata[7:0];
                  end else begin
                     state     <= StRsp;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= 16'h0000;
                  end
               end
            end
            StLo: begin
               if (word_q) begin
                  // Strobe stays high; only address and data move to the high byte.
                  state     <= StHi;
                  ram_addr  <= hi_off_q;
                  ram_wdata <= wdata_hi_q;
               end else begin
                  ram_we <= 1'b0;
                  ram_re <= 1'b0;
                  if (we_q) begin
                     state     <= StRsp;
                     rsp_valid <= 1'b1;
                  end else begin
                     state <= StCap;
                  end
               end
            end
            StHi: begin
               ram_we <= 1'b0;
               ram_re <= 1'b0;
               if (we_q) begin
                  state     <= StRsp;
                  rsp_valid <= 1'b1;
               end else begin
                  lo_byte_q <= ram_rdata;
                  state     <= StCap;
               end
            end
            StCap: begin
               rsp_rdata <= word_q ? {ram_rdata, lo_byte_q} : {8'h00, ram_rdata};
               rsp_valid <= 1'b1;
               state     <= StRsp;
            end
            StRsp: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= 16'h0000;
               state     <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
